// File: rtl/dmem_mmio.sv
// Data-memory stage: word RAM with byte/half lanes plus MMIO window (TX FIFO, cycle counter, tohost).
// Latency: loads combinational (same cycle), stores and MMIO side effects commit on the rising edge.
// Backpressure: TX FIFO drains on tx_valid&&tx_ready; pushes into a full FIFO without a pop are dropped and flag overflow.
module dmem_mmio #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    input  logic [2:0]  Funct3,
    output logic [31:0] ReadData,
    output logic        Misaligned,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        halt,
    output logic [31:0] halt_code
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [2:0] F_B  = 3'b000;
    localparam logic [2:0] F_H  = 3'b001;
    localparam logic [2:0] F_W  = 3'b010;
    localparam logic [2:0] F_BU = 3'b100;
    localparam logic [2:0] F_HU = 3'b101;

    localparam logic [1:0] OFF_TX     = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CYCLE  = 2'd2;
    localparam logic [1:0] OFF_TOHOST = 2'd3;

    logic [1:0]    boff;
    logic [1:0]    moff;
    logic [AW-1:0] widx;
    logic          is_byte, is_half, is_word, size_ok;
    logic          access, is_mmio, wr_ok;
    logic          ram_we, mmio_we;
    logic          push_req, push, pop, cyc_clr, tohost_we;

    assign boff    = ALUResult[1:0];
    assign moff    = ALUResult[3:2];
    assign widx    = ALUResult[AW+1:2];
    assign is_byte = (Funct3 == F_B) || (Funct3 == F_BU);
    assign is_half = (Funct3 == F_H) || (Funct3 == F_HU);
    assign is_word = (Funct3 == F_W);
    assign size_ok = is_byte || is_half || is_word;
    assign access  = MemRead || MemWrite;
    assign is_mmio = (ALUResult[31:4] == MMIO_BASE[31:4]);

    assign Misaligned = access && ((is_half && boff[0]) || (is_word && (boff != 2'b00)));

    // Stores are suppressed while reset is high, after halt, and on any misaligned access.
    assign wr_ok     = MemWrite && !Misaligned && !halt && !reset;
    assign ram_we    = wr_ok && !is_mmio && size_ok;
    assign mmio_we   = wr_ok && is_mmio && is_word;
    assign push_req  = mmio_we && (moff == OFF_TX);
    assign cyc_clr   = mmio_we && (moff == OFF_CYCLE);
    assign tohost_we = mmio_we && (moff == OFF_TOHOST);

    logic [3:0]  be;
    logic [31:0] wdat;

    always_comb begin
        be   = 4'b0000;
        wdat = WriteData;
        if (is_byte) begin
            be   = 4'b0001 << boff;
            wdat = {4{WriteData[7:0]}};
        end else if (is_half) begin
            be   = boff[1] ? 4'b1100 : 4'b0011;
            wdat = {2{WriteData[15:0]}};
        end else if (is_word) begin
            be   = 4'b1111;
        end
    end

    logic [31:0] ram [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) ram[widx][8*i +: 8] <= wdat[8*i +: 8];
            end
        end
    end

    logic [31:0] rword;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;
    logic [31:0] ram_rd;

    assign rword = ram[widx];
    assign rbyte = rword[{boff, 3'b000} +: 8];
    assign rhalf = boff[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        ram_rd = '0;
        case (Funct3)
            F_B:     ram_rd = {{24{rbyte[7]}}, rbyte};
            F_BU:    ram_rd = {24'b0, rbyte};
            F_H:     ram_rd = {{16{rhalf[15]}}, rhalf};
            F_HU:    ram_rd = {16'b0, rhalf};
            F_W:     ram_rd = rword;
            default: ram_rd = '0;
        endcase
    end

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          empty, full, overflow;
    logic [31:0]   cycle;
    logic [31:0]   status;
    logic [31:0]   mmio_rd;

    assign empty    = (count == '0);
    assign full     = (count == CW'(FIFO_DEPTH));
    assign tx_valid = !empty;
    assign tx_data  = empty ? 8'h00 : fifo_mem[rd_ptr];
    assign pop      = tx_valid && tx_ready;
    // A full FIFO still takes a byte when the head leaves on the same edge.
    assign push     = push_req && (!full || pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push_req && !push) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= WriteData[7:0];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle     <= '0;
            halt      <= 1'b0;
            halt_code <= '0;
        end else begin
            if (cyc_clr)    cycle <= '0;
            else if (!halt) cycle <= cycle + 32'd1;
            if (tohost_we) begin
                halt      <= 1'b1;
                halt_code <= WriteData;
            end
        end
    end

    assign status = {28'b0, overflow, full, empty, halt};

    always_comb begin
        mmio_rd = '0;
        if (is_word) begin
            case (moff)
                OFF_STATUS: mmio_rd = status;
                OFF_CYCLE:  mmio_rd = cycle;
                default:    mmio_rd = '0;
            endcase
        end
    end

    assign ReadData = (MemRead && !Misaligned) ? (is_mmio ? mmio_rd : ram_rd) : '0;

endmodule
